// File: rtl/particle_scheduler_pkg.sv
// Shared definitions for the particle scheduler and the physics writer that fills particle memory.
package particle_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_t;

  // Particle word layout {z, y, x}, each a 16-bit float.
  localparam int FP_WIDTH = 16;
  localparam int X_LSB    = 0;
  localparam int Y_LSB    = 16;
  localparam int Z_LSB    = 32;
  localparam int WORD_W   = 3 * FP_WIDTH;

endpackage

// File: rtl/particle_scheduler_if.sv
// Projector handshake: one particle coordinate triple plus an issue strobe, paced by projector ready.
interface particle_scheduler_if;
  import particle_scheduler_pkg::*;

  logic [FP_WIDTH-1:0] f_x_out;
  logic [FP_WIDTH-1:0] f_y_out;
  logic [FP_WIDTH-1:0] f_z_out;
  logic                data_valid_out;
  logic                proj_ready_in;

  modport master (
    output f_x_out,
    output f_y_out,
    output f_z_out,
    output data_valid_out,
    input  proj_ready_in
  );

  modport slave (
    input  f_x_out,
    input  f_y_out,
    input  f_z_out,
    input  data_valid_out,
    output proj_ready_in
  );

endinterface

// File: rtl/particle_scheduler.sv
// Per-frame walker over particle memory: fetches each (x, y, z) and hands it to the projector
// under its ready handshake, then waits for the projector to drain before signalling frame done.
module particle_scheduler
  import particle_scheduler_pkg::*;
#(
  parameter int NUM_PARTICLES = 64,
  parameter int ADDR_WIDTH    = 6,
  parameter int BRAM_LATENCY  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [WORD_W-1:0]     mem_data_in,
  particle_scheduler_if.master  proj,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [7:0]            overrun_count_out
);

  localparam int LAT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(BRAM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(NUM_PARTICLES - 1);

  sched_state_t          r_state;
  sched_state_t          w_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [LAT_W-1:0]      r_lat;
  logic [FP_WIDTH-1:0]   r_x;
  logic [FP_WIDTH-1:0]   r_y;
  logic [FP_WIDTH-1:0]   r_z;
  logic [7:0]            r_ovr;
  logic                  w_start;
  logic                  w_capture;
  logic                  w_issue;
  logic                  w_advance;

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // The strobe is combinational on ready, so a valid can never appear while ready is low.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_capture = 1'b0;
    w_issue   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (frame_start_in) begin
          w_start = 1'b1;
          w_next  = FETCH;
        end
      end
      FETCH: begin
        if (r_lat == LAT_LAST) begin
          w_capture = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (proj.proj_ready_in) begin
          w_issue = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_next = DRAIN;
          end else begin
            w_advance = 1'b1;
            w_next    = FETCH;
          end
        end
      end
      DRAIN: begin
        if (proj.proj_ready_in) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_idx <= '0;
      r_lat <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_ovr <= '0;
    end else begin
      if (w_start)   r_idx <= '0;
      if (w_advance) r_idx <= r_idx + ADDR_WIDTH'(1);
      if (w_start || w_capture)  r_lat <= '0;
      else if (r_state == FETCH) r_lat <= r_lat + LAT_W'(1);
      if (w_capture) begin
        r_x <= mem_data_in[X_LSB +: FP_WIDTH];
        r_y <= mem_data_in[Y_LSB +: FP_WIDTH];
        r_z <= mem_data_in[Z_LSB +: FP_WIDTH];
      end
      // DONE is not IDLE, so a start landing on the done cycle is an overrun too.
      if (frame_start_in && (r_state != IDLE) && (r_ovr != 8'hFF))
        r_ovr <= r_ovr + 8'd1;
    end
  end

  assign mem_addr_out        = r_idx;
  assign proj.f_x_out        = r_x;
  assign proj.f_y_out        = r_y;
  assign proj.f_z_out        = r_z;
  assign proj.data_valid_out = w_issue;
  assign busy_out            = (r_state == FETCH) || (r_state == ISSUE) || (r_state == DRAIN);
  assign frame_done_out      = (r_state == DONE);
  assign overrun_count_out   = r_ovr;

endmodule

// File: tb/tb_particle_scheduler.sv
// Directed bench for particle_scheduler with 4 particles and a 2-cycle particle memory model.
module tb_particle_scheduler;

  localparam int NP = 4;
  localparam int AW = 6;
  localparam int BL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fs  = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] addr_d = '0;
  logic [47:0]   mem_data;
  logic          busy;
  logic          done;
  logic [7:0]    ovr;

  particle_scheduler_if pif();

  particle_scheduler #(
    .NUM_PARTICLES(NP),
    .ADDR_WIDTH   (AW),
    .BRAM_LATENCY (BL)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .frame_start_in   (fs),
    .mem_addr_out     (mem_addr),
    .mem_data_in      (mem_data),
    .proj             (pif),
    .busy_out         (busy),
    .frame_done_out   (done),
    .overrun_count_out(ovr)
  );

  always #5 clk = ~clk;

  // Memory word i = {i+0x300, i+0x200, i+0x100}, visible one edge after the address.
  always @(posedge clk) addr_d <= mem_addr;
  assign mem_data = {16'h0300 + 16'(addr_d), 16'h0200 + 16'(addr_d), 16'h0100 + 16'(addr_d)};

  int         n_strobe = 0;
  int         n_done   = 0;
  int         bad_overlap = 0;
  int         bad_noready = 0;
  logic [15:0] rec_x [0:255];
  logic [15:0] rec_y [0:255];
  logic [15:0] rec_z [0:255];
  logic [AW-1:0] rec_a [0:255];

  always @(negedge clk) begin
    if (pif.data_valid_out === 1'b1) begin
      rec_x[n_strobe[7:0]] <= pif.f_x_out;
      rec_y[n_strobe[7:0]] <= pif.f_y_out;
      rec_z[n_strobe[7:0]] <= pif.f_z_out;
      rec_a[n_strobe[7:0]] <= mem_addr;
      n_strobe <= n_strobe + 1;
      if (pif.proj_ready_in !== 1'b1) bad_noready <= bad_noready + 1;
      if (done === 1'b1) bad_overlap <= bad_overlap + 1;
    end
    if (done === 1'b1) n_done <= n_done + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    #1;
    chk({tag, "_strobes"}, 32'(n_strobe - base), 32'(NP));
    for (int i = 0; i < NP; i++) begin
      chk({tag, "_x"}, 32'(rec_x[base + i]), 32'(16'h0100 + i));
      chk({tag, "_y"}, 32'(rec_y[base + i]), 32'(16'h0200 + i));
      chk({tag, "_z"}, 32'(rec_z[base + i]), 32'(16'h0300 + i));
      chk({tag, "_addr"}, 32'(rec_a[base + i]), 32'(i));
    end
  endtask

  initial begin
    int base;
    int dbase;
    int cyc;
    logic [15:0] held_x;

    pif.proj_ready_in = 1'b1;

    // Reset held with frame_start toggling
    for (int i = 0; i < 3; i++) begin
      fs = (i != 1);
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(pif.data_valid_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovr", 32'(ovr), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_fx", 32'(pif.f_x_out), 32'd0);
    end
    fs  = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_strobes", 32'(n_strobe), 32'd0);

    // Nominal pass: 4 particles x 3 cycles + drain cycle
    base  = n_strobe;
    dbase = n_done;
    start_frame();
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_addr0", 32'(mem_addr), 32'd0);
    wait_done(cyc);
    chk("nom_cycles", 32'(cyc), 32'd13);
    chk("nom_done_busy", 32'(busy), 32'd0);
    check_frame("nom", base);
    tick();
    chk("nom_done_pulse", 32'(done), 32'd0);
    chk("nom_idle_busy", 32'(busy), 32'd0);
    chk("nom_done_count", 32'(n_done - dbase), 32'd1);

    // Backpressure: ready low in ISSUE for 10 cycles
    base = n_strobe;
    pif.proj_ready_in = 1'b0;
    start_frame();
    tick();
    tick();
    held_x = pif.f_x_out;
    chk("bp_capture_x", 32'(held_x), 32'h0100);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_no_valid", 32'(pif.data_valid_out), 32'd0);
    end
    chk("bp_no_strobe", 32'(n_strobe - base), 32'd0);
    chk("bp_x_stable", 32'(pif.f_x_out), 32'(held_x));
    chk("bp_y_stable", 32'(pif.f_y_out), 32'h0200);
    pif.proj_ready_in = 1'b1;
    #1;
    chk("bp_valid_on_ready", 32'(pif.data_valid_out), 32'd1);
    wait_done(cyc);
    chk("bp_done_seen", 32'(cyc > 0), 32'd1);
    check_frame("bp", base);

    // Overrun: 3 pulses mid-pass
    tick();
    base = n_strobe;
    start_frame();
    for (int i = 0; i < 3; i++) begin
      fs = 1'b1;
      tick();
      fs = 1'b0;
      tick();
    end
    wait_done(cyc);
    chk("ovr_cycles", 32'(cyc + 6), 32'd13);
    chk("ovr_count3", 32'(ovr), 32'd3);
    check_frame("ovr", base);

    // Back-to-back: start the cycle after frame done
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    base = n_strobe;
    start_frame();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_ovr_same", 32'(ovr), 32'd3);
    wait_done(cyc);
    chk("b2b_cycles", 32'(cyc), 32'd13);
    check_frame("b2b", base);

    // Start landing on the done cycle is an overrun and does not launch a pass
    fs = 1'b1;
    tick();
    fs = 1'b0;
    chk("done_start_ovr", 32'(ovr), 32'd4);
    chk("done_start_busy", 32'(busy), 32'd0);
    tick();
    chk("done_start_idle", 32'(busy), 32'd0);

    // Reset after the second strobe
    base = n_strobe;
    start_frame();
    for (int k = 0; k < 50; k++) begin
      if (n_strobe - base >= 2) break;
      tick();
    end
    chk("mid_two_strobes", 32'(n_strobe - base), 32'd2);
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_valid", 32'(pif.data_valid_out), 32'd0);
    chk("mid_rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b1;
    repeat (10) tick();
    chk("mid_no_more", 32'(n_strobe - base), 32'd2);
    chk("mid_idle", 32'(busy), 32'd0);
    base = n_strobe;
    start_frame();
    chk("mid_restart_addr", 32'(mem_addr), 32'd0);
    chk("mid_restart_busy", 32'(busy), 32'd1);
    wait_done(cyc);
    chk("mid_restart_cycles", 32'(cyc), 32'd13);
    check_frame("mid", base);

    // Saturation: 300 ignored starts while stalled in ISSUE
    tick();
    base = n_strobe;
    pif.proj_ready_in = 1'b0;
    start_frame();
    for (int i = 0; i < 300; i++) begin
      fs = 1'b1;
      tick();
      fs = 1'b0;
      tick();
      if (i == 253) chk("sat_254", 32'(ovr), 32'd254);
    end
    chk("sat_255", 32'(ovr), 32'd255);
    chk("sat_busy", 32'(busy), 32'd1);
    pif.proj_ready_in = 1'b1;
    wait_done(cyc);
    chk("sat_done_seen", 32'(cyc > 0), 32'd1);
    chk("sat_hold", 32'(ovr), 32'd255);
    check_frame("sat", base);

    tick();
    chk("no_overlap", 32'(bad_overlap), 32'd0);
    chk("no_valid_without_ready", 32'(bad_noready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
